alu_op_sequencer: RTL and testbench

Sequential front end that drives the 32-bit ALU datapath (AND/OR/ADD with Binvert/Carryin).
- Accepts operation requests over a valid/ready handshake.
- Decodes each opcode into the ALU control lines and presents registered operands to the ALU.
- Captures the ALU Result and CarryOut, and returns a response over a second valid/ready handshake.
- Also sequences SLT, and 64-bit ADD/SUB as two chained 32-bit ALU passes.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_op_decode.sv | 37 +++
 rtl/alu_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode, ALU operation and FSM state encodings for the ALU op sequencer
package alu_seq_pkg;

  localparam logic [2:0] OPC_AND   = 3'b000;
  localparam logic [2:0] OPC_OR    = 3'b001;
  localparam logic [2:0] OPC_ADD   = 3'b010;
  localparam logic [2:0] OPC_SUB   = 3'b011;
  localparam logic [2:0] OPC_SLT   = 3'b100;
  localparam logic [2:0] OPC_ADD64 = 3'b101;
  localparam logic [2:0] OPC_SUB64 = 3'b110;
  localparam logic [2:0] OPC_ILL   = 3'b111;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode to ALU control line decode
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] op,
  output logic       binvert,
  output logic       carryin,
  output logic [1:0] operation,
  output logic       is_wide,
  output logic       is_slt,
  output logic       is_err
);

  always_comb begin
    binvert   = 1'b0;
    carryin   = 1'b0;
    operation = OP_AND;
    case (op)
      OPC_OR:            operation = OP_OR;
      OPC_ADD,
      OPC_ADD64:         operation = OP_ADD;
      OPC_SUB,
      OPC_SLT,
      OPC_SUB64: begin
        binvert   = 1'b1;
        carryin   = 1'b1;
        operation = OP_ADD;
      end
      default:           operation = OP_AND;
    endcase
  end

  assign is_wide = (op == OPC_ADD64) || (op == OPC_SUB64);
  assign is_slt  = (op == OPC_SLT);
  assign is_err  = (op == OPC_ILL);

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/response front end sequencing one or two ALU passes per op
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a_lo,
  input  logic [WIDTH-1:0] req_b_lo,
  input  logic [WIDTH-1:0] req_a_hi,
  input  logic [WIDTH-1:0] req_b_hi,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_binvert,
  output logic             alu_carryin,
  output logic [1:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result_lo,
  output logic [WIDTH-1:0] rsp_result_hi,
  output logic             rsp_carry,
  output logic             rsp_err
);

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_lo_q, b_lo_q, a_hi_q, b_hi_q;
  logic             carry_lo_q;

  logic       d_binvert, d_carryin, d_is_wide, d_is_slt, d_is_err;
  logic [1:0] d_operation;
  logic       slt_ovf, slt_bit, is_arith;

  alu_op_decode u_decode (
    .op        (op_q),
    .binvert   (d_binvert),
    .carryin   (d_carryin),
    .operation (d_operation),
    .is_wide   (d_is_wide),
    .is_slt    (d_is_slt),
    .is_err    (d_is_err)
  );

  // Signed compare from the subtract pass, corrected for two's-complement overflow
  assign slt_ovf  = (a_lo_q[WIDTH-1] != b_lo_q[WIDTH-1]) && (alu_result[WIDTH-1] != a_lo_q[WIDTH-1]);
  assign slt_bit  = alu_result[WIDTH-1] ^ slt_ovf;
  assign is_arith = (d_operation == OP_ADD) && !d_is_slt;

  assign req_ready = rst_n && (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_binvert   = 1'b0;
    alu_carryin   = 1'b0;
    alu_operation = OP_AND;
    case (state)
      ST_LO: begin
        alu_a         = a_lo_q;
        alu_b         = b_lo_q;
        alu_binvert   = d_binvert;
        alu_carryin   = d_carryin;
        alu_operation = d_operation;
      end
      ST_HI: begin
        alu_a         = a_hi_q;
        alu_b         = b_hi_q;
        alu_binvert   = d_binvert;
        alu_carryin   = carry_lo_q;
        alu_operation = OP_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      op_q          <= '0;
      a_lo_q        <= '0;
      b_lo_q        <= '0;
      a_hi_q        <= '0;
      b_hi_q        <= '0;
      carry_lo_q    <= 1'b0;
      rsp_result_lo <= '0;
      rsp_result_hi <= '0;
      rsp_carry     <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            a_lo_q <= req_a_lo;
            b_lo_q <= req_b_lo;
            a_hi_q <= req_a_hi;
            b_hi_q <= req_b_hi;
            state  <= ST_LO;
          end
        end
        ST_LO: begin
          rsp_err <= d_is_err;
          if (d_is_wide) begin
            rsp_result_lo <= alu_result;
            carry_lo_q    <= alu_carryout;
            state         <= ST_HI;
          end else begin
            rsp_result_hi <= '0;
            if (d_is_err) begin
              rsp_result_lo <= '0;
              rsp_carry     <= 1'b0;
            end else if (d_is_slt) begin
              rsp_result_lo <= {{(WIDTH-1){1'b0}}, slt_bit};
              rsp_carry     <= 1'b0;
            end else begin
              rsp_result_lo <= alu_result;
              rsp_carry     <= is_arith ? alu_carryout : 1'b0;
            end
            state <= ST_RESP;
          end
        end
        ST_HI: begin
          rsp_result_hi <= alu_result;
          rsp_carry     <= alu_carryout;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a behavioural ALU and reference model
module tb_alu_op_sequencer;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a_lo, req_b_lo, req_a_hi, req_b_hi;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_binvert, alu_carryin, alu_carryout;
  logic [1:0]  alu_operation;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result_lo, rsp_result_hi;
  logic        rsp_carry, rsp_err;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        c;
    logic        e;
  } exp_t;

  exp_t expq[$];

  alu_op_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a_lo(req_a_lo), .req_b_lo(req_b_lo), .req_a_hi(req_a_hi), .req_b_hi(req_b_hi),
    .alu_a(alu_a), .alu_b(alu_b), .alu_binvert(alu_binvert), .alu_carryin(alu_carryin),
    .alu_operation(alu_operation), .alu_result(alu_result), .alu_carryout(alu_carryout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result_lo(rsp_result_lo), .rsp_result_hi(rsp_result_hi),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  // Behavioural 32-bit ALU: AND / OR / ADD with Binvert and Carryin
  logic [31:0] b_eff;
  logic [32:0] alu_sum;
  always_comb begin
    b_eff   = alu_binvert ? ~alu_b : alu_b;
    alu_sum = {1'b0, alu_a} + {1'b0, b_eff} + {32'b0, alu_carryin};
    case (alu_operation)
      2'b00:   alu_result = alu_a & b_eff;
      2'b01:   alu_result = alu_a | b_eff;
      2'b10:   alu_result = alu_sum[31:0];
      default: alu_result = 32'h0;
    endcase
    alu_carryout = alu_sum[32];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] alo, blo, ahi, bhi);
    logic [63:0] a, b;
    logic [64:0] s;
    exp_t r;
    a = {ahi, alo};
    b = {bhi, blo};
    r.lo = 32'h0; r.hi = 32'h0; r.c = 1'b0; r.e = 1'b0;
    case (op)
      3'd0: r.lo = alo & blo;
      3'd1: r.lo = alo | blo;
      3'd2: begin s = {33'b0, alo} + {33'b0, blo}; r.lo = s[31:0]; r.c = s[32]; end
      3'd3: begin r.lo = alo - blo; r.c = (alo >= blo); end
      3'd4: r.lo = {31'b0, ($signed(alo) < $signed(blo))};
      3'd5: begin s = {1'b0, a} + {1'b0, b}; {r.hi, r.lo} = s[63:0]; r.c = s[64]; end
      3'd6: begin {r.hi, r.lo} = a - b; r.c = (a >= b); end
      default: r.e = 1'b1;
    endcase
    return r;
  endfunction

  // {binvert, carryin, operation} the low pass should present
  function automatic logic [3:0] dec_exp(input logic [2:0] op);
    case (op)
      3'd1:             return 4'b0001;
      3'd2, 3'd5:       return 4'b0010;
      3'd3, 3'd4, 3'd6: return 4'b1110;
      default:          return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hffffffff;
      2:       return 32'h80000000;
      3:       return 32'h7fffffff;
      4:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_rsp", 64'(1), 64'(0));
        end else begin
          e = expq.pop_front();
          chk("rsp_result_lo", 64'(rsp_result_lo), 64'(e.lo));
          chk("rsp_result_hi", 64'(rsp_result_hi), 64'(e.hi));
          chk("rsp_carry", 64'(rsp_carry), 64'(e.c));
          chk("rsp_err", 64'(rsp_err), 64'(e.e));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] alo, blo, ahi, bhi);
    int n;
    req_op = op; req_a_lo = alo; req_b_lo = blo; req_a_hi = ahi; req_b_hi = bhi;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(0), 64'(1));
    @(posedge clk);
    expq.push_back(model(op, alo, blo, ahi, bhi));
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] alo, blo, ahi, bhi);
    int n, k;
    logic wide, clo;
    logic [3:0] dx;
    wide = (op == 3'd5) || (op == 3'd6);
    dx   = dec_exp(op);
    clo  = (op == 3'd5) ? (({1'b0, alo} + {1'b0, blo}) >> 32) != 33'd0 : (alo >= blo);
    issue(op, alo, blo, ahi, bhi);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("lo_ctrl", 64'({alu_binvert, alu_carryin, alu_operation}), 64'(dx));
        chk("lo_a", 64'(alu_a), 64'(alo));
        chk("lo_b", 64'(alu_b), 64'(blo));
      end
      if (n == 2 && wide) begin
        chk("hi_ctrl", 64'({alu_binvert, alu_carryin, alu_operation}), 64'({dx[3], clo, 2'b10}));
        chk("hi_a", 64'(alu_a), 64'(ahi));
        chk("hi_b", 64'(alu_b), 64'(bhi));
      end
    end while (!rsp_valid && n < 10);
    chk("latency", 64'(n), wide ? 64'(3) : 64'(2));
    k = 0;
    while (!(rsp_valid && rsp_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!(rsp_valid && rsp_ready)) chk("handshake_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [31:0] s_lo, s_hi;
    logic s_c, s_e;
    int n;
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 3'd0;
    req_a_lo = 32'h0; req_b_lo = 32'h0; req_a_hi = 32'h0; req_b_hi = 32'h0;
    #3;
    chk("reset_req_ready_low", 64'(req_ready), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_words", {rsp_result_hi, rsp_result_lo}, 64'(0));
    chk("reset_alu", {alu_a, alu_b}, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_req_ready", 64'(req_ready), 64'(1));
    chk("post_reset_flags", 64'({rsp_carry, rsp_err, alu_binvert, alu_carryin, alu_operation}), 64'(0));

    run(3'd0, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h0, 32'h0);
    run(3'd1, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h0, 32'h0);
    run(3'd3, 32'd7, 32'd5, 32'h0, 32'h0);
    run(3'd3, 32'd5, 32'd7, 32'h0, 32'h0);
    run(3'd4, 32'h80000000, 32'h00000001, 32'h0, 32'h0);
    run(3'd4, 32'h00000001, 32'h80000000, 32'h0, 32'h0);
    run(3'd5, 32'hffffffff, 32'h00000001, 32'h00000001, 32'h0);
    run(3'd6, 32'h0, 32'h1, 32'h0, 32'h0);

    // Backpressure: response must hold while rsp_ready is low
    @(negedge clk);
    ready_mode = 0;
    issue(3'd2, 32'h12345678, 32'h9abcdef0, 32'h0, 32'h0);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    s_lo = rsp_result_lo; s_hi = rsp_result_hi; s_c = rsp_carry; s_e = rsp_err;
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable", {rsp_result_hi, rsp_result_lo}, {s_hi, s_lo});
      chk("bp_stable_flags", 64'({rsp_valid, rsp_carry, rsp_err}), 64'({1'b1, s_c, s_e}));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
    end
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_req_ready_after", 64'(req_ready), 64'(1));
    chk("bp_rsp_valid_after", 64'(rsp_valid), 64'(0));
    run(3'd2, 32'hffffffff, 32'h00000001, 32'h0, 32'h0);

    // Asynchronous reset during the high pass of a wide add
    @(negedge clk);
    issue(3'd5, 32'hffffffff, 32'h1, 32'h1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_hi_a", 64'(alu_a), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_alu_ab", {alu_a, alu_b}, 64'(0));
    chk("rst_alu_ctrl", 64'({alu_binvert, alu_carryin, alu_operation}), 64'(0));
    chk("rst_rsp_words", {rsp_result_hi, rsp_result_lo}, 64'(0));
    chk("rst_rsp_flags", 64'({rsp_valid, rsp_carry, rsp_err, req_ready}), 64'(0));
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_req_ready", 64'(req_ready), 64'(1));
    run(3'd2, 32'd3, 32'd4, 32'h0, 32'h0);
    run(3'd7, 32'hdeadbeef, 32'h12345678, 32'h1, 32'h2);

    ready_mode = 2;
    for (int i = 0; i < 150; i++) begin
      run(3'($urandom_range(0, 7)), pick(), pick(), pick(), pick());
    end
    ready_mode = 1;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(expq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
